// File: rtl/fpga_reset_pkg.sv
// Shared types and sizing helpers for the board-level reset sequencer.
package fpga_reset_pkg;

    typedef enum logic [1:0] {
        ASSERT = 2'd0,
        HOLD   = 2'd1,
        RUN    = 2'd2
    } rst_state_e;

    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/fpga_debounce.sv
// Two-flop synchroniser plus debounce counter for an asynchronous push-button level.
module fpga_debounce
    import fpga_reset_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 1000000,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_db
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_r;
    logic          sync_r;
    logic          db_r;
    logic [CW-1:0] cnt_r;

    // Bring the raw button level into the clk domain
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= IDLE_LEVEL;
            sync_r <= IDLE_LEVEL;
        end else begin
            meta_r <= btn_raw;
            sync_r <= meta_r;
        end
    end

    // Accept a new level only after it has disagreed for DEBOUNCE_CYCLES consecutive samples
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
            db_r  <= IDLE_LEVEL;
        end else if (sync_r == db_r) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_LAST) begin
            db_r  <= sync_r;
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign btn_db = db_r;

endmodule

// File: rtl/fpga_reset_seq.sv
// Board reset sequencer: debounced button and synchronised clock-ready gate a
// programmable SoC reset hold, with status LED and saturating reset-event counter.
module fpga_reset_seq
    import fpga_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 1024,
    parameter bit BTN_ACTIVE_LOW  = 1'b1,
    parameter int LED_HALF_PERIOD = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_i,
    input  logic       clk_ready_i,
    output logic       soc_rst_no,
    output logic [1:0] state_o,
    output logic       led_o,
    output logic [7:0] rst_count_o
);

    localparam int            HW        = cnt_width(HOLD_CYCLES);
    localparam int            LW        = cnt_width(LED_HALF_PERIOD);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [LW-1:0] LED_LAST  = LW'(LED_HALF_PERIOD - 1);
    localparam logic          BTN_IDLE  = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic          btn_db_s;
    logic          release_ok_s;
    logic          rdy_meta_r;
    logic          rdy_sync_r;
    rst_state_e    state_r;
    rst_state_e    next_state_s;
    logic [HW-1:0] hold_cnt_r;
    logic [HW-1:0] next_hold_cnt_s;
    logic [LW-1:0] led_cnt_r;
    logic [LW-1:0] next_led_cnt_s;
    logic          led_r;
    logic          next_led_s;
    logic          soc_rst_n_r;
    logic [7:0]    rst_count_r;
    logic [7:0]    next_count_s;

    fpga_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .IDLE_LEVEL      (BTN_IDLE)
    ) u_btn_debounce (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_i),
        .btn_db  (btn_db_s)
    );

    // Clock-ready is a level qualifier, so it is synchronised but not debounced
    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_meta_r <= 1'b0;
            rdy_sync_r <= 1'b0;
        end else begin
            rdy_meta_r <= clk_ready_i;
            rdy_sync_r <= rdy_meta_r;
        end
    end

    assign release_ok_s = (btn_db_s == BTN_IDLE) && rdy_sync_r;

    // Next-state, hold countdown and reset-event counter
    always_comb begin
        next_state_s    = state_r;
        next_hold_cnt_s = hold_cnt_r;
        next_count_s    = rst_count_r;
        case (state_r)
            ASSERT: begin
                if (release_ok_s) begin
                    next_state_s    = HOLD;
                    next_hold_cnt_s = HOLD_LOAD;
                end else begin
                    next_state_s = ASSERT;
                end
            end
            HOLD: begin
                if (!release_ok_s) begin
                    next_state_s = ASSERT;
                end else if (hold_cnt_r == '0) begin
                    next_state_s = RUN;
                end else begin
                    next_hold_cnt_s = hold_cnt_r - 1'b1;
                end
            end
            RUN: begin
                if (!release_ok_s) begin
                    next_state_s = ASSERT;
                    if (rst_count_r != 8'hFF) begin
                        next_count_s = rst_count_r + 8'd1;
                    end else begin
                        next_count_s = rst_count_r;
                    end
                end else begin
                    next_state_s = RUN;
                end
            end
            default: begin
                next_state_s = ASSERT;
            end
        endcase
    end

    // LED follows the next state; blink phase restarts on every entry into HOLD
    always_comb begin
        next_led_s     = led_r;
        next_led_cnt_s = led_cnt_r;
        case (next_state_s)
            ASSERT: begin
                next_led_s     = 1'b0;
                next_led_cnt_s = '0;
            end
            HOLD: begin
                if (state_r != HOLD) begin
                    next_led_s     = 1'b0;
                    next_led_cnt_s = '0;
                end else if (led_cnt_r == LED_LAST) begin
                    next_led_s     = ~led_r;
                    next_led_cnt_s = '0;
                end else begin
                    next_led_cnt_s = led_cnt_r + 1'b1;
                end
            end
            RUN: begin
                next_led_s     = 1'b1;
                next_led_cnt_s = '0;
            end
            default: begin
                next_led_s     = 1'b0;
                next_led_cnt_s = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ASSERT;
            hold_cnt_r  <= '0;
            led_cnt_r   <= '0;
            led_r       <= 1'b0;
            soc_rst_n_r <= 1'b0;
            rst_count_r <= 8'd0;
        end else begin
            state_r     <= next_state_s;
            hold_cnt_r  <= next_hold_cnt_s;
            led_cnt_r   <= next_led_cnt_s;
            led_r       <= next_led_s;
            soc_rst_n_r <= (next_state_s == RUN);
            rst_count_r <= next_count_s;
        end
    end

    assign soc_rst_no  = soc_rst_n_r;
    assign state_o     = state_r;
    assign led_o       = led_r;
    assign rst_count_o = rst_count_r;

endmodule

// File: tb/tb_fpga_reset_seq.sv
// Randomised scoreboard bench for fpga_reset_seq against a cycle-level behavioural model.
module tb_fpga_reset_seq;

    localparam int D = 8;
    localparam int H = 4;
    localparam int L = 3;

    logic       clk;
    logic       reset;
    logic       btn_i;
    logic       clk_ready_i;
    logic       soc_rst_no;
    logic [1:0] state_o;
    logic       led_o;
    logic [7:0] rst_count_o;

    typedef struct packed {
        logic       soc;
        logic [1:0] st;
        logic       led;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    fpga_reset_seq #(
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .BTN_ACTIVE_LOW  (1'b1),
        .LED_HALF_PERIOD (L)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_i       (btn_i),
        .clk_ready_i (clk_ready_i),
        .soc_rst_no  (soc_rst_no),
        .state_o     (state_o),
        .led_o       (led_o),
        .rst_count_o (rst_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: raw inputs delayed two cycles; button level accepted after D equal
    // differing samples; "ok_run" = consecutive cycles all release conditions held.
    logic m_btn_d1, m_btn_d2, m_rdy_d1, m_rdy_d2, m_db;
    logic m_win[$];
    int   m_ok_run;
    int   m_count;

    function automatic logic [1:0] state_of(input int run);
        if (run == 0)      return 2'd0;
        else if (run <= H) return 2'd1;
        else               return 2'd2;
    endfunction

    initial begin
        exp_t e;
        bit   ok;
        bit   same;
        m_btn_d1 = 1'b1; m_btn_d2 = 1'b1; m_rdy_d1 = 1'b0; m_rdy_d2 = 1'b0;
        m_db = 1'b1; m_ok_run = 0; m_count = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_btn_d1 = 1'b1; m_btn_d2 = 1'b1; m_rdy_d1 = 1'b0; m_rdy_d2 = 1'b0;
                m_db = 1'b1; m_win.delete(); m_ok_run = 0; m_count = 0;
            end else begin
                ok = (m_db == 1'b1) && m_rdy_d2;
                if (!ok && state_of(m_ok_run) == 2'd2 && m_count < 255) m_count++;
                m_ok_run = ok ? ((m_ok_run > H) ? H + 1 : m_ok_run + 1) : 0;
                m_win.push_back(m_btn_d2);
                if (m_win.size() > D) void'(m_win.pop_front());
                if (m_win.size() == D) begin
                    same = 1'b1;
                    foreach (m_win[i]) if (m_win[i] != m_win[0]) same = 1'b0;
                    if (same && m_win[0] != m_db) m_db = m_win[0];
                end
                m_btn_d2 = m_btn_d1; m_btn_d1 = btn_i;
                m_rdy_d2 = m_rdy_d1; m_rdy_d1 = clk_ready_i;
            end
            e.st  = state_of(m_ok_run);
            e.soc = (e.st == 2'd2);
            e.led = (e.st == 2'd2) ? 1'b1 :
                    (e.st == 2'd1) ? ((((m_ok_run - 1) / L) % 2) == 1) : 1'b0;
            e.cnt = 8'(m_count);
            exp_q.push_back(e);
        end
    end

    // Monitor: compare every presented cycle against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("soc_rst_no", {7'd0, soc_rst_no}, {7'd0, e.soc});
                chk("state_o", {6'd0, state_o}, {6'd0, e.st});
                chk("led_o", {7'd0, led_o}, {7'd0, e.led});
                chk("rst_count_o", rst_count_o, e.cnt);
            end
        end
    end

    task automatic hold(input logic b, input logic r, input int n);
        @(negedge clk);
        btn_i = b;
        clk_ready_i = r;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        reset = 1'b1; btn_i = 1'b1; clk_ready_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_soc", {7'd0, soc_rst_no}, 8'd0);
        chk("reset_state", {6'd0, state_o}, 8'd0);
        @(negedge clk); reset = 1'b0;
        repeat (6) @(posedge clk); #1;
        chk("powerup_still_low", {7'd0, soc_rst_no}, 8'd0);
        @(posedge clk); #1;
        chk("powerup_rise_at_7", {7'd0, soc_rst_no}, 8'd1);
        chk("powerup_count", rst_count_o, 8'd0);

        hold(1'b0, 1'b1, 5);
        hold(1'b1, 1'b1, 20); #1;
        chk("glitch_soc", {7'd0, soc_rst_no}, 8'd1);
        chk("glitch_count", rst_count_o, 8'd0);

        @(negedge clk); btn_i = 1'b0;
        repeat (10) @(posedge clk); #1;
        chk("press_still_high", {7'd0, soc_rst_no}, 8'd1);
        @(posedge clk); #1;
        chk("press_fall_at_11", {7'd0, soc_rst_no}, 8'd0);
        chk("press_count", rst_count_o, 8'd1);
        repeat (9) @(posedge clk);
        @(negedge clk); btn_i = 1'b1;
        repeat (14) @(posedge clk); #1;
        chk("release_still_low", {7'd0, soc_rst_no}, 8'd0);
        @(posedge clk); #1;
        chk("release_rise_at_15", {7'd0, soc_rst_no}, 8'd1);

        hold(1'b1, 1'b0, 6);
        hold(1'b1, 1'b1, 4);
        hold(1'b1, 1'b0, 6);
        hold(1'b1, 1'b1, 12); #1;
        chk("hold_drop_count", rst_count_o, 8'd2);
        chk("hold_drop_recover", {7'd0, soc_rst_no}, 8'd1);

        for (int i = 0; i < 300; i++) begin
            hold(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
                 $urandom_range(1, 20));
        end
        hold(1'b1, 1'b1, 30);

        for (int i = 0; i < 260; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                hold(1'b0, 1'b1, 12);
                hold(1'b1, 1'b1, 20);
            end else begin
                hold(1'b1, 1'b0, 4);
                hold(1'b1, 1'b1, 9);
            end
        end
        #1;
        chk("saturation", rst_count_o, 8'd255);

        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("midrun_reset_soc", {7'd0, soc_rst_no}, 8'd0);
        chk("midrun_reset_state", {6'd0, state_o}, 8'd0);
        chk("midrun_reset_led", {7'd0, led_o}, 8'd0);
        chk("midrun_reset_count", rst_count_o, 8'd0);
        @(negedge clk); reset = 1'b0;
        repeat (10) @(posedge clk); #1;
        chk("after_reset_run", {7'd0, soc_rst_no}, 8'd1);

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
